// File: rtl/spi_dma_controller.sv
// spi_dma_controller: decodes the byte command protocol coming from spi_slave and
// moves bursts between SPI and one of CHANNELS BRAM planes. It also launches the
// processing engine and keeps a sticky error flag that STATUS reads and clears.
module spi_dma_controller #(
    parameter int  CHANNELS = 3,
    parameter int  ADDR_W   = 17,
    parameter int  READ_LAT = 1,
    localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ss,
    input  logic              spi_cycle_done,
    input  logic [7:0]        spi_byte_in,
    output logic [7:0]        spi_byte_out,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [CH_W-1:0]   bram_channel,
    output logic              bram_we,
    output logic [7:0]        bram_data_in,
    input  logic [7:0]        bram_data_out,
    output logic              pdi_active,
    input  logic              pdi_done,
    output logic              busy,
    output logic              error
);

    localparam int ABYTES = (ADDR_W + 7) / 8;
    localparam int HC_W   = (ABYTES > 1) ? $clog2(ABYTES) : 1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_HDR_ADDR,
        S_HDR_LEN,
        S_CHECK,
        S_WRITE,
        S_READ,
        S_DRAIN,
        S_PROC,
        S_STATUS
    } state_t;

    state_t            state, state_nxt;
    logic [3:0]        op;
    logic              byte_ev;
    logic              op_known;
    logic [ADDR_W-1:0] start, len, count;
    logic [3:0]        ch_q;
    logic              op_rd;
    logic [HC_W-1:0]   hdr_cnt;
    logic              hdr_last;
    logic [ADDR_W:0]   end_sum;
    logic              hdr_bad;
    logic              burst_last;
    logic              rd_issue;
    logic [READ_LAT:0] rd_pipe;
    logic              err_set, err_clr;
    logic [7:0]        status_word;

    // A byte only counts while the frame is open; ss high means the master gave up.
    assign op       = spi_byte_in[7:4];
    assign byte_ev  = spi_cycle_done & ~ss;
    assign op_known = (op == 4'd1) || (op == 4'd2) || (op == 4'd3) || (op == 4'd4);
    assign hdr_last = (hdr_cnt == HC_W'(ABYTES - 1));

    // End of burst is checked one bit wider so a burst ending exactly at the top is legal.
    assign end_sum    = {1'b0, start} + {1'b0, len};
    assign hdr_bad    = ({1'b0, ch_q} >= 5'(CHANNELS)) ||
                        (end_sum[ADDR_W] && (end_sum[ADDR_W-1:0] != '0));
    assign burst_last = ((count + ADDR_W'(1)) == len);

    // Reads are issued on entry to READ and after every exchange except the last one.
    assign rd_issue = ((state == S_CHECK) && (state_nxt == S_READ)) ||
                      ((state == S_READ) && byte_ev && !burst_last);

    assign err_set = ((state == S_IDLE) && byte_ev && !op_known) ||
                     ((state == S_CHECK) && hdr_bad) ||
                     ((state == S_PROC) && spi_cycle_done);
    assign err_clr = (state == S_STATUS) && byte_ev;

    assign status_word  = {pdi_active, error, 2'b00, 4'(CHANNELS)};
    assign bram_channel = ch_q[CH_W-1:0];

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    // Next-state decode; ss high drops every state but PROC back to IDLE.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (byte_ev) begin
                    case (op)
                        4'd1, 4'd2: state_nxt = S_HDR_ADDR;
                        4'd3:       state_nxt = S_PROC;
                        4'd4:       state_nxt = S_STATUS;
                        default:    state_nxt = S_IDLE;
                    endcase
                end
            end
            S_HDR_ADDR: if (byte_ev && hdr_last) state_nxt = S_HDR_LEN;
            S_HDR_LEN:  if (byte_ev && hdr_last) state_nxt = S_CHECK;
            S_CHECK: begin
                if (hdr_bad)          state_nxt = S_DRAIN;
                else if (len == '0)   state_nxt = S_IDLE;
                else if (op_rd)       state_nxt = S_READ;
                else                  state_nxt = S_WRITE;
            end
            S_WRITE, S_READ: if (byte_ev && burst_last) state_nxt = S_IDLE;
            S_DRAIN:  state_nxt = S_DRAIN;
            S_PROC:   if (pdi_done) state_nxt = S_IDLE;
            S_STATUS: if (byte_ev) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
        if (ss && (state != S_PROC)) state_nxt = S_IDLE;
    end

    // Outputs that follow directly from the current state.
    always_comb begin
        busy       = (state != S_IDLE);
        pdi_active = (state == S_PROC);
    end

    // Header capture, burst counting, BRAM strobes, read prefetch and SPI reply byte.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            start        <= '0;
            len          <= '0;
            count        <= '0;
            ch_q         <= '0;
            op_rd        <= 1'b0;
            hdr_cnt      <= '0;
            rd_pipe      <= '0;
            bram_addr    <= '0;
            bram_we      <= 1'b0;
            bram_data_in <= '0;
            spi_byte_out <= '0;
            error        <= 1'b0;
        end else begin
            bram_we <= 1'b0;
            rd_pipe <= {rd_pipe[READ_LAT-1:0], rd_issue};
            error   <= err_set | (error & ~err_clr);
            case (state)
                S_IDLE: begin
                    hdr_cnt <= '0;
                    if (byte_ev) begin
                        count <= '0;
                        if ((op == 4'd1) || (op == 4'd2)) begin
                            ch_q  <= spi_byte_in[3:0];
                            op_rd <= (op == 4'd2);
                        end
                    end
                end
                S_HDR_ADDR: begin
                    if (byte_ev) begin
                        // Shifting through an ADDR_W register drops the unused top bits.
                        start   <= ADDR_W'({start, spi_byte_in});
                        hdr_cnt <= hdr_last ? '0 : hdr_cnt + HC_W'(1);
                    end
                end
                S_HDR_LEN: begin
                    if (byte_ev) begin
                        len     <= ADDR_W'({len, spi_byte_in});
                        hdr_cnt <= hdr_last ? '0 : hdr_cnt + HC_W'(1);
                    end
                end
                S_CHECK: begin
                    count <= '0;
                    if (rd_issue) bram_addr <= start;
                end
                S_WRITE: begin
                    if (byte_ev) begin
                        bram_we      <= 1'b1;
                        bram_data_in <= spi_byte_in;
                        bram_addr    <= start + count;
                        count        <= count + ADDR_W'(1);
                    end
                end
                S_READ: begin
                    // Data is valid READ_LAT cycles after the address; load it then.
                    if (rd_pipe[READ_LAT]) spi_byte_out <= bram_data_out;
                    if (byte_ev) begin
                        count <= count + ADDR_W'(1);
                        if (rd_issue) bram_addr <= start + count + ADDR_W'(1);
                    end
                end
                default: ;
            endcase
            if (state_nxt == S_PROC)   spi_byte_out <= 8'hB5;
            if (state_nxt == S_STATUS) spi_byte_out <= status_word;
            if ((state != S_IDLE) && (state_nxt == S_IDLE)) spi_byte_out <= 8'h00;
        end
    end

endmodule

// File: tb/tb_spi_dma_controller.sv
// Bench for spi_dma_controller: a command-level model (expected memory, sticky
// error flag, expected write queue) plus directed frames with literal checks.
module tb_spi_dma_controller;

    localparam int CHANNELS = 3;
    localparam int ADDR_W   = 17;
    localparam int READ_LAT = 1;
    localparam int CH_W     = 2;
    localparam int ABYTES   = 3;
    localparam int GAP      = 6;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              ss = 1'b1;
    logic              spi_cycle_done = 1'b0;
    logic [7:0]        spi_byte_in = 8'h00;
    logic [7:0]        spi_byte_out;
    logic [ADDR_W-1:0] bram_addr;
    logic [CH_W-1:0]   bram_channel;
    logic              bram_we;
    logic [7:0]        bram_data_in;
    logic [7:0]        bram_data_out;
    logic              pdi_active;
    logic              pdi_done = 1'b0;
    logic              busy;
    logic              error;

    spi_dma_controller #(.CHANNELS(CHANNELS), .ADDR_W(ADDR_W), .READ_LAT(READ_LAT)) dut (
        .clk(clk), .rst(rst), .ss(ss), .spi_cycle_done(spi_cycle_done),
        .spi_byte_in(spi_byte_in), .spi_byte_out(spi_byte_out),
        .bram_addr(bram_addr), .bram_channel(bram_channel), .bram_we(bram_we),
        .bram_data_in(bram_data_in), .bram_data_out(bram_data_out),
        .pdi_active(pdi_active), .pdi_done(pdi_done), .busy(busy), .error(error)
    );

    always #5 clk = ~clk;

    // BRAM stand-in: small array indexed by channel and low address byte.
    logic [7:0] bram [0:1023];
    logic [7:0] rd_p [READ_LAT];
    logic [9:0] bidx;
    assign bidx          = {bram_channel, bram_addr[7:0]};
    assign bram_data_out = rd_p[READ_LAT-1];

    always @(posedge clk) begin
        if (bram_we) bram[bidx] <= bram_data_in;
        rd_p[0] <= bram[bidx];
        for (int i = 1; i < READ_LAT; i++) rd_p[i] <= rd_p[i-1];
    end

    typedef struct {
        int         k;
        logic [7:0] d;
    } wr_t;

    int         n_cmp = 0;
    int         n_fail = 0;
    int         wr_seen = 0;
    wr_t        exq[$];
    logic [7:0] model_mem [int];
    logic       model_err = 1'b0;
    logic [7:0] payload[$];
    logic [7:0] rd_got[$];
    logic [7:0] last_out;

    function automatic int key(input int ch, input int a);
        return ch * (1 << ADDR_W) + a;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, got, exp);
        end
    endtask

    // Every BRAM write must match the next model-predicted write.
    task automatic compare_loop();
        wr_t e;
        forever begin
            @(negedge clk);
            if (rst && bram_we) begin
                wr_seen++;
                chk("we_while_ss", {31'b0, ss}, 0);
                if (exq.size() == 0) begin
                    chk("we_unexpected", {31'b0, bram_we}, 0);
                end else begin
                    e = exq.pop_front();
                    chk("we_addr", key(int'(bram_channel), int'(bram_addr)), e.k);
                    chk("we_data", {24'b0, bram_data_in}, {24'b0, e.d});
                end
            end
        end
    endtask

    task automatic xfer(input logic [7:0] b, input logic [7:0] exp, input bit do_chk,
                        input string name);
        repeat (GAP) @(negedge clk);
        last_out = spi_byte_out;
        if (do_chk) chk(name, {24'b0, spi_byte_out}, {24'b0, exp});
        spi_byte_in    = b;
        spi_cycle_done = 1'b1;
        @(negedge clk);
        spi_cycle_done = 1'b0;
    endtask

    task automatic send_hdr(input int addr, input int len);
        for (int i = ABYTES - 1; i >= 0; i--) xfer(8'(addr >> (8 * i)), 8'h00, 1'b0, "hdr");
        for (int i = ABYTES - 1; i >= 0; i--) xfer(8'(len >> (8 * i)), 8'h00, 1'b0, "hdr");
    endtask

    // One complete frame; the model predicts writes, read bytes and the error flag.
    task automatic run_cmd(input logic [7:0] cmd, input int addr, input int len);
        int op;
        int ch;
        bit bad;
        op = int'(cmd[7:4]);
        ch = int'(cmd[3:0]);
        rd_got.delete();
        ss = 1'b0;
        repeat (2) @(negedge clk);
        xfer(cmd, 8'h00, 1'b0, "cmd");
        if (op == 1 || op == 2) begin
            send_hdr(addr, len);
            bad = (ch >= CHANNELS) || (addr + len > (1 << ADDR_W));
            if (bad) begin
                model_err = 1'b1;
                foreach (payload[i]) xfer(payload[i], 8'h00, 1'b0, "drain");
            end else if (len == 0) begin
                repeat (3) @(negedge clk);
                chk("len0_idle", {31'b0, busy}, 0);
            end else if (op == 1) begin
                for (int i = 0; i < len; i++) begin
                    exq.push_back('{k: key(ch, addr + i), d: payload[i]});
                    model_mem[key(ch, addr + i)] = payload[i];
                    xfer(payload[i], 8'h00, 1'b0, "wr");
                end
            end else begin
                for (int i = 0; i < len; i++) begin
                    xfer(8'h00, model_mem[key(ch, addr + i)], 1'b1, "rd_byte");
                    rd_got.push_back(last_out);
                end
                repeat (2) @(negedge clk);
                chk("rd_tail", {24'b0, spi_byte_out}, 0);
            end
        end else if (op == 4) begin
            xfer(8'h00, {1'b0, model_err, 2'b00, 4'(CHANNELS)}, 1'b1, "status");
            model_err = 1'b0;
        end else if (op != 3) begin
            model_err = 1'b1;
        end
        repeat (2) @(negedge clk);
        ss = 1'b1;
        repeat (3) @(negedge clk);
        chk("busy_end", {31'b0, busy}, 0);
        chk("err_state", {31'b0, error}, {31'b0, model_err});
    endtask

    initial begin
        int w0;
        fork
            compare_loop();
        join_none

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_out", {24'b0, spi_byte_out}, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_err", {31'b0, error}, 0);
        chk("rst_we", {31'b0, bram_we}, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Unknown opcode raises the sticky error.
        payload.delete();
        run_cmd(8'h70, 0, 0);
        chk("err_lit", {31'b0, error}, 1);

        // Reset in the middle of a write burst, after two data bytes.
        ss = 1'b0;
        repeat (2) @(negedge clk);
        xfer(8'h11, 8'h00, 1'b0, "cmd");
        send_hdr(32'h20, 4);
        exq.push_back('{k: key(1, 32'h20), d: 8'h5A});
        exq.push_back('{k: key(1, 32'h21), d: 8'h5B});
        model_mem[key(1, 32'h20)] = 8'h5A;
        model_mem[key(1, 32'h21)] = 8'h5B;
        xfer(8'h5A, 8'h00, 1'b0, "wr");
        xfer(8'h5B, 8'h00, 1'b0, "wr");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rst_out", {24'b0, spi_byte_out}, 0);
        chk("mid_rst_addr", {15'b0, bram_addr}, 0);
        chk("mid_rst_ch", {30'b0, bram_channel}, 0);
        chk("mid_rst_we", {31'b0, bram_we}, 0);
        chk("mid_rst_din", {24'b0, bram_data_in}, 0);
        chk("mid_rst_pdi", {31'b0, pdi_active}, 0);
        chk("mid_rst_busy", {31'b0, busy}, 0);
        chk("mid_rst_err", {31'b0, error}, 0);
        ss = 1'b1;
        model_err = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        run_cmd(8'h40, 0, 0);
        chk("status_lit0", {24'b0, last_out}, 32'h03);

        // Normal write then read back.
        payload = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
        w0 = wr_seen;
        run_cmd(8'h11, 32'h10, 4);
        chk("wr_count", wr_seen - w0, 4);
        payload.delete();
        run_cmd(8'h21, 32'h10, 4);
        for (int i = 0; i < 4; i++) chk("rd_lit", {24'b0, rd_got[i]}, 32'hA0 + i);

        // Bad channel: no write, error reported then cleared by STATUS.
        w0 = wr_seen;
        run_cmd(8'h13, 32'h10, 2);
        chk("badch_nowr", wr_seen - w0, 0);
        run_cmd(8'h40, 0, 0);
        chk("status_lit1", {24'b0, last_out}, 32'h43);
        run_cmd(8'h40, 0, 0);
        chk("status_lit2", {24'b0, last_out}, 32'h03);

        // Burst running past the top of the address space is refused.
        payload = '{8'hE0, 8'hE1, 8'hE2};
        w0 = wr_seen;
        run_cmd(8'h10, 32'h1FFFE, 3);
        chk("ovf_nowr", wr_seen - w0, 0);
        chk("ovf_err_lit", {31'b0, error}, 1);
        run_cmd(8'h40, 0, 0);
        chk("status_lit3", {24'b0, last_out}, 32'h43);

        // Burst ending exactly at the top is legal.
        payload = '{8'hC1, 8'hC2};
        w0 = wr_seen;
        run_cmd(8'h12, 32'h1FFFE, 2);
        chk("top_wr_count", wr_seen - w0, 2);
        payload.delete();
        run_cmd(8'h22, 32'h1FFFE, 2);
        chk("top_rd0", {24'b0, rd_got[0]}, 32'hC1);
        chk("top_rd1", {24'b0, rd_got[1]}, 32'hC2);

        // Zero-length read goes straight back to idle.
        run_cmd(8'h21, 32'h10, 0);

        // START: engine runs 100 cycles; ss toggling must not abort it.
        ss = 1'b0;
        repeat (2) @(negedge clk);
        xfer(8'h30, 8'h00, 1'b0, "cmd");
        for (int i = 1; i <= 100; i++) begin
            chk("pdi_active", {31'b0, pdi_active}, 1);
            chk("proc_out", {24'b0, spi_byte_out}, 32'hB5);
            if (i == 30) ss = 1'b1;
            if (i == 50) ss = 1'b0;
            if (i == 70) ss = 1'b1;
            if (i == 100) pdi_done = 1'b1;
            @(negedge clk);
        end
        pdi_done = 1'b0;
        chk("pdi_off", {31'b0, pdi_active}, 0);
        chk("proc_busy_off", {31'b0, busy}, 0);
        chk("proc_err", {31'b0, error}, {31'b0, model_err});
        repeat (4) @(negedge clk);
        chk("exq_drained", exq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
